// File: rtl/mem_wb_stage_pkg.sv
// Shared MEM/WB definitions: reset/enable levels, NOP values, ctrl stall bit positions.
// Also holds the per-edge action decode used by the MEM->WB register.
// Pure declarations; no timing or backpressure of its own.
package mem_wb_stage_pkg;

    localparam logic        RST_ENABLE    = 1'b1;
    localparam logic        WRITE_DISABLE = 1'b0;
    localparam logic [4:0]  NOP_REG_ADDR  = 5'd0;
    localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

    // Bit positions inside the ctrl block's stall vector.
    localparam int STALL_MEM_BIT = 4;
    localparam int STALL_WB_BIT  = 5;

    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_FLUSH,
        ACT_BUBBLE,
        ACT_HOLD,
        ACT_CAPTURE
    } wb_act_e;

    // One action per edge, highest priority first. stall_wb without
    // stall_mem never comes from ctrl and is treated as a normal capture.
    function automatic wb_act_e next_action(input logic rst,
                                            input logic flush,
                                            input logic stall_mem,
                                            input logic stall_wb);
        if (rst == RST_ENABLE)         return ACT_RESET;
        else if (flush)                return ACT_FLUSH;
        else if (stall_mem && !stall_wb) return ACT_BUBBLE;
        else if (stall_mem)            return ACT_HOLD;
        else                           return ACT_CAPTURE;
    endfunction

endpackage

// File: rtl/mem_wb_stage_wr_arbiter.sv
// Gates per-channel register writes with valid and drops same-address losers.
// Combinational, zero latency.
// No flow control; the enclosing register decides when the result is used.
module wb_wr_arbiter #(
    parameter int NUM_CH = 1,
    parameter int ADDR_W = 5
) (
    input  logic [NUM_CH-1:0]        valid_i,
    input  logic [NUM_CH-1:0]        wreg_i,
    input  logic [NUM_CH*ADDR_W-1:0] waddr_i,
    output logic [NUM_CH-1:0]        we_o
);

    logic [NUM_CH-1:0] gated;

    // A channel keeps its write only if no program-later channel writes the same register.
    always_comb begin
        gated = wreg_i & valid_i;
        we_o  = gated;
        for (int j = 0; j < NUM_CH; j++) begin
            for (int k = j + 1; k < NUM_CH; k++) begin
                if (gated[j] && gated[k] &&
                    (waddr_i[j*ADDR_W +: ADDR_W] == waddr_i[k*ADDR_W +: ADDR_W])) begin
                    we_o[j] = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM->WB pipeline register: N reg-write channels, HI/LO, LLbit, retired counter.
// Latency one cycle; all outputs registered, no input-to-output comb path.
// Backpressure via ctrl stalls: stall_mem+stall_wb holds, stall_mem alone bubbles, flush kills.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_CH = 1,
    parameter int CNT_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall_mem,
    input  logic                     stall_wb,
    input  logic                     flush,
    input  logic [NUM_CH-1:0]        mem_valid,
    input  logic [NUM_CH-1:0]        mem_wreg,
    input  logic [NUM_CH*ADDR_W-1:0] mem_waddr,
    input  logic [NUM_CH*DATA_W-1:0] mem_wdata,
    input  logic                     mem_whilo,
    input  logic [DATA_W-1:0]        mem_hi,
    input  logic [DATA_W-1:0]        mem_lo,
    input  logic                     mem_llbit_we,
    input  logic                     mem_llbit,
    output logic [NUM_CH-1:0]        wb_valid,
    output logic [NUM_CH-1:0]        wb_wreg,
    output logic [NUM_CH*ADDR_W-1:0] wb_waddr,
    output logic [NUM_CH*DATA_W-1:0] wb_wdata,
    output logic                     wb_whilo,
    output logic [DATA_W-1:0]        wb_hi,
    output logic [DATA_W-1:0]        wb_lo,
    output logic                     wb_llbit_we,
    output logic                     wb_llbit,
    output logic [CNT_W-1:0]         retired
);

    localparam logic [NUM_CH*ADDR_W-1:0] NOP_ADDRS = {NUM_CH{ADDR_W'(NOP_REG_ADDR)}};
    localparam logic [NUM_CH*DATA_W-1:0] ZERO_DATA = {NUM_CH{DATA_W'(ZERO_WORD)}};
    localparam logic [DATA_W-1:0]        ZERO_ONE  = DATA_W'(ZERO_WORD);

    logic [NUM_CH-1:0]        valid_d,   valid_q;
    logic [NUM_CH-1:0]        wreg_d,    wreg_q;
    logic [NUM_CH*ADDR_W-1:0] waddr_d,   waddr_q;
    logic [NUM_CH*DATA_W-1:0] wdata_d,   wdata_q;
    logic                     whilo_d,   whilo_q;
    logic [DATA_W-1:0]        hi_d,      hi_q;
    logic [DATA_W-1:0]        lo_d,      lo_q;
    logic                     llbit_we_d, llbit_we_q;
    logic                     llbit_d,   llbit_q;
    logic [CNT_W-1:0]         retired_d, retired_q;

    logic [NUM_CH-1:0]        we_arb;
    wb_act_e                  act;

    // Number of real instructions on the input channels, sized to the counter.
    function automatic logic [CNT_W-1:0] popcount(input logic [NUM_CH-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

    wb_wr_arbiter #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W)
    ) u_wr_arbiter (
        .valid_i (mem_valid),
        .wreg_i  (mem_wreg),
        .waddr_i (mem_waddr),
        .we_o    (we_arb)
    );

    assign act = next_action(rst, flush, stall_mem, stall_wb);

    // Next-state selection: hold by default, zero on reset/flush/bubble, load on capture.
    always_comb begin
        valid_d    = valid_q;
        wreg_d     = wreg_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        whilo_d    = whilo_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        llbit_we_d = llbit_we_q;
        llbit_d    = llbit_q;
        retired_d  = retired_q;
        case (act)
            ACT_RESET, ACT_FLUSH, ACT_BUBBLE: begin
                valid_d    = '0;
                wreg_d     = {NUM_CH{WRITE_DISABLE}};
                waddr_d    = NOP_ADDRS;
                wdata_d    = ZERO_DATA;
                whilo_d    = WRITE_DISABLE;
                hi_d       = ZERO_ONE;
                lo_d       = ZERO_ONE;
                llbit_we_d = WRITE_DISABLE;
                llbit_d    = 1'b0;
                if (act == ACT_RESET) begin
                    retired_d = '0;
                end
            end
            ACT_CAPTURE: begin
                valid_d    = mem_valid;
                wreg_d     = we_arb;
                waddr_d    = mem_waddr;
                wdata_d    = mem_wdata;
                // HI/LO and LL/SC only ever issue on channel 0.
                whilo_d    = mem_whilo & mem_valid[0];
                hi_d       = mem_hi;
                lo_d       = mem_lo;
                llbit_we_d = mem_llbit_we & mem_valid[0];
                llbit_d    = mem_llbit;
                retired_d  = retired_q + popcount(mem_valid);
            end
            default: ; // ACT_HOLD keeps every register
        endcase
    end

    // Pipeline register bank; reset is folded into the next-state logic.
    always_ff @(posedge clk) begin
        valid_q    <= valid_d;
        wreg_q     <= wreg_d;
        waddr_q    <= waddr_d;
        wdata_q    <= wdata_d;
        whilo_q    <= whilo_d;
        hi_q       <= hi_d;
        lo_q       <= lo_d;
        llbit_we_q <= llbit_we_d;
        llbit_q    <= llbit_d;
        retired_q  <= retired_d;
    end

    assign wb_valid    = valid_q;
    assign wb_wreg     = wreg_q;
    assign wb_waddr    = waddr_q;
    assign wb_wdata    = wdata_q;
    assign wb_whilo    = whilo_q;
    assign wb_hi       = hi_q;
    assign wb_lo       = lo_q;
    assign wb_llbit_we = llbit_we_q;
    assign wb_llbit    = llbit_q;
    assign retired     = retired_q;

endmodule
